nibble_serial_add_seq: RTL and testbench
========================================

Name: nibble_serial_add_seq

Overview:
Sequencer that shares one 4-bit combinational ripple adder (a/b/cin -> s/cout) across a wider add or subtract, one nibble per clock, LSB first. Each nibble's cout is carried into the next nibble's cin. Subtract is two's complement: invert B and set the initial cin to 1. Sits between a host issuing start/operands and the external 4-bit adder instance; the adder stays purely combinational.

Parameters:
NIBBLES, 4, number of nibbles per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
sub  in  1  0 = A+B, 1 = A-B; latched with start
op_a  in  W  operand A; latched with start
op_b  in  W  operand B; latched with start
busy  out  1  high while an operation is in RUN
done  out  1  one-cycle pulse when the result is valid
result  out  W  sum/difference; held until the next accepted start
carry_out  out  1  final carry; for sub, 1 = no borrow
overflow  out  1  signed two's-complement overflow
add_a  out  4  nibble of A driven to the shared adder
add_b  out  4  nibble of B, or ~B when sub=1, driven to the adder
add_cin  out  1  carry into the adder
add_s  in  4  adder sum, combinational from add_a/add_b/add_cin
add_cout  in  1  adder carry out, combinational

Behaviour:
- States: IDLE, RUN. Internal state: nibble index k (0..NIBBLES-1), carry register c, latched a_q, b_q, sub_q.
- Reset (rst=1 at an edge): state=IDLE, k=0, c=0, busy=0, done=0, result=0, carry_out=0, overflow=0. Reset overrides every other input.
- Reset during RUN aborts the operation. No done is produced and the partial result is cleared.
- IDLE, start=1 at an edge:
  - latch a_q=op_a, b_q=op_b, sub_q=sub;
  - set c=sub, k=0, result=0;
  - go to RUN; busy=1 from the next cycle.
- IDLE, start=0: no change. result, carry_out and overflow hold.
- RUN, combinational drive:
  - add_a = a_q[4k+3:4k];
  - add_b = b_q[4k+3:4k], XORed with {4{sub_q}};
  - add_cin = c.
- RUN, each edge: result[4k+3:4k] <= add_s; c <= add_cout; k <= k+1.
- Completion, at the edge where k = NIBBLES-1:
  - state -> IDLE, busy=0, done=1 for exactly one cycle;
  - carry_out <= add_cout;
  - overflow <= (a_q[W-1] == b_eff[W-1]) && (add_s[3] != a_q[W-1]), where b_eff = b_q ^ {W{sub_q}}.
- Latency: start accepted at edge E0. RUN occupies cycles after E0 .. E0+NIBBLES. done is high in the cycle after edge E0+NIBBLES. busy is high exactly NIBBLES cycles.
- start while busy=1 is ignored: not queued, no effect on the latched operands.
- start=1 in the done cycle is accepted, because the block is already in IDLE. This allows back-to-back operations with a throughput of NIBBLES+1 cycles. done still pulses for the finished operation, and result keeps the old value until that accepting edge clears it.
- In IDLE, add_a=0, add_b=0, add_cin=0, so the adder sees no spurious activity.
- Changes on op_a, op_b or sub during RUN do not affect the operation.
- All arithmetic is modulo 2^W; the carry beyond bit W-1 appears only on carry_out.

Test Plan:
- Add, NIBBLES=4: start, sub=0, op_a=0x1234, op_b=0x4321 -> busy high for 4 cycles; add_a sequence 4,3,2,1; done pulse in the 5th cycle; result=0x5555, carry_out=0, overflow=0.
- Carry chain: op_a=0xFFFF + op_b=0x0001 -> add_cin sequence 0,1,1,1; result=0x0000, carry_out=1, overflow=0. Then 0x7FFF + 0x0001 -> result=0x8000, carry_out=0, overflow=1.
- Subtract: sub=1, 0x0005 - 0x0007 -> add_b first nibble 0x8, initial add_cin=1; result=0xFFFE, carry_out=0 (borrow), overflow=0. Then 0x8000 - 0x0001 -> result=0x7FFF, overflow=1.
- Busy handling: pulse start again in RUN cycle 2 with different operands -> ignored; original result still produced; exactly one done pulse.
- Back-to-back: hold start=1 continuously with 0x0001+0x0001 -> done every 5 cycles, each result=0x0002, busy low only in the done cycles.
- Reset mid-op: assert rst in RUN cycle 2 -> next cycle busy=0, done=0, result=0, carry_out=0; no done pulse follows; a new start afterwards completes normally.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: runs a W-bit add/subtract through one shared
// external 4-bit adder, one nibble per clock, LSB first.
module nibble_serial_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 overflow,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_s,
   input  logic                 add_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [KW-1:0] k;
   logic [KW+1:0] base;
   logic          c;
   logic          sub_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          last;
   logic          accept;
   logic          ovf_d;

   assign base  = {k, 2'b00};
   assign last  = (k == KLAST);
   assign ovf_d = (a_q[W-1] == (b_q[W-1] ^ sub_q))
                && (add_s[3] != a_q[W-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // adder inputs are forced to zero outside RUN
   always_comb begin
      state_d = state;
      busy    = 1'b0;
      accept  = 1'b0;
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = a_q[base +: 4];
            add_b   = b_q[base +: 4] ^ {4{sub_q}};
            add_cin = c;
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k         <= '0;
         c         <= 1'b0;
         sub_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_q    <= op_a;
            b_q    <= op_b;
            sub_q  <= sub;
            c      <= sub;
            k      <= '0;
            result <= '0;
         end else if (busy) begin
            result[base +: 4] <= add_s;
            c <= add_cout;
            k <= k + 1'b1;
            if (last) begin
               k         <= '0;
               done      <= 1'b1;
               carry_out <= add_cout;
               overflow  <= ovf_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// tb_nibble_serial_add_seq: scoreboard bench with a behavioural
// 4-bit adder closing the loop around the sequencer.
module tb_nibble_serial_add_seq;

   localparam int N = 4;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_cout;
   logic [4:0]   sum5;

   typedef struct packed {
      logic [W-1:0] r;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   assign sum5     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
   assign add_s    = sum5[3:0];
   assign add_cout = sum5[4];

   nibble_serial_add_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .result(result), .carry_out(carry_out),
      .overflow(overflow), .add_a(add_a), .add_b(add_b),
      .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
   );

   task automatic issue(input logic [W-1:0] a, b,
                        input logic s,
                        input logic [W-1:0] er,
                        input logic eco, eov);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      q.push_back('{r: er, co: eco, ov: eov});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0;
      op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, carry_out, overflow, result} !== 20'h0) begin
         errors++;
         $display("FAIL reset_status: got %b%b%b%b %h want 0000 0000",
                  busy, done, carry_out, overflow, result);
      end
      checks++;
      if ({add_a, add_b, add_cin} !== 9'h0) begin
         errors++;
         $display("FAIL reset_adder: got %h %h %b want 0 0 0",
                  add_a, add_b, add_cin);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL idle_hold: got busy=%b done=%b want 0 0",
                  busy, done);
      end
   endtask

   task automatic test_busy();
      exp_t e;
      int   nact;
      issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
      @(negedge clk);
      op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_run3: got busy=%b want 1", busy);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         errors++;
         $display("FAIL busy_done: got busy=%b done=%b want 0 1",
                  busy, done);
      end
      e = q.pop_front();
      checks++;
      if ({result, carry_out, overflow} !== {e.r, e.co, e.ov}) begin
         errors++;
         $display("FAIL busy_result: got %h %b %b want %h %b %b",
                  result, carry_out, overflow, e.r, e.co, e.ov);
      end
      nact = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) nact++;
      end
      checks++;
      if (nact !== 0) begin
         errors++;
         $display("FAIL busy_ignored: got %0d active cycles want 0",
                  nact);
      end
   endtask

   task automatic test_back_to_back();
      exp_t       e;
      logic [1:0] want;
      op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0; start = 1'b1;
      repeat (3) q.push_back('{r: 16'h0002, co: 1'b0, ov: 1'b0});
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         want = (i % 5 == 0) ? 2'b01 : 2'b10;
         checks++;
         if ({busy, done} !== want) begin
            errors++;
            $display("FAIL b2b_cyc%0d: got busy/done=%b want %b",
                     i, {busy, done}, want);
         end
         if (i % 5 == 0) begin
            e = q.pop_front();
            checks++;
            if (result !== e.r) begin
               errors++;
               $display("FAIL b2b_res%0d: got %h want %h",
                        i, result, e.r);
            end
         end
         if (i == 15) start = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL b2b_end: got busy=%b queue=%0d want 0 0",
                  busy, q.size());
      end
   endtask

   task automatic test_arith();
      logic [W-1:0] ta [5];
      logic [W-1:0] tb [5];
      logic         ts [5];
      logic [W-1:0] tr [5];
      logic         tc [5];
      logic         tv [5];
      logic [3:0]   an;
      logic [3:0]   bn;
      logic         c;
      logic [4:0]   t;
      exp_t         e;
      ta = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
      tb = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
      ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tr = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
      tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int j = 0; j < 5; j++) begin
         issue(ta[j], tb[j], ts[j], tr[j], tc[j], tv[j]);
         c = ts[j];
         for (int i = 0; i < N; i++) begin
            an = ta[j][4*i +: 4];
            bn = tb[j][4*i +: 4] ^ {4{ts[j]}};
            checks++;
            if ({busy, add_a, add_b, add_cin} !== {1'b1, an, bn, c}) begin
               errors++;
               $display("FAIL op%0d_nib%0d: got %b %h %h %b want 1 %h %h %b",
                        j, i, busy, add_a, add_b, add_cin, an, bn, c);
            end
            t = {1'b0, an} + {1'b0, bn} + {4'b0, c};
            c = t[4];
            @(negedge clk);
         end
         checks++;
         if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL op%0d_done: got busy=%b done=%b want 0 1",
                     j, busy, done);
         end
         e = q.pop_front();
         checks++;
         if ({result, carry_out, overflow} !== {e.r, e.co, e.ov}) begin
            errors++;
            $display("FAIL op%0d_result: got %h %b %b want %h %b %b",
                     j, result, carry_out, overflow, e.r, e.co, e.ov);
         end
         @(negedge clk);
         checks++;
         if ({busy, done, add_a, add_b, add_cin} !== 11'h0) begin
            errors++;
            $display("FAIL op%0d_idle: got %b %b %h %h %b want 0 0 0 0 0",
                     j, busy, done, add_a, add_b, add_cin);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   nact;
      issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
      e = q.pop_back();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, carry_out, overflow, result} !== 20'h0) begin
         errors++;
         $display("FAIL abort_clear: got %b%b%b%b %h want 0000 0000",
                  busy, done, carry_out, overflow, result);
      end
      nact = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) nact++;
      end
      checks++;
      if (nact !== 0) begin
         errors++;
         $display("FAIL abort_nodone: got %0d active cycles want 0",
                  nact);
      end
      issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
      repeat (N) @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({done, result, carry_out, overflow} !== {1'b1, e.r, e.co, e.ov}) begin
         errors++;
         $display("FAIL restart: got %b %h %b %b want 1 %h %b %b",
                  done, result, carry_out, overflow, e.r, e.co, e.ov);
      end
   endtask

   initial begin
      test_reset();
      test_busy();
      test_back_to_back();
      test_arith();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
